uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_rx_sync_edge.sv | 47 ++++
 rtl/uart_rx.sv | 157 +++++++++++++++
 tb/tb_uart_rx.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the UART receiver and its matching transmitter.
// Holds the default clock/baud parameters, the derived cycles-per-bit count,
// the frame width, the FSM state encoding and the sample-point helper.
package uart_pkg;

  localparam int CLK_FREQ_DEF     = 50_000_000;
  localparam int BAUD_DEF         = 9600;
  localparam int BAUD_CNT_MAX_DEF = CLK_FREQ_DEF / BAUD_DEF;
  localparam int DATA_BITS        = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // Mid-bit sample point: half a bit period after the bit began.
  function automatic int sample_point(input int cnt_max);
    return cnt_max / 2;
  endfunction

endpackage

// File: rtl/uart_rx_sync_edge.sv
// sync_edge -- two-flop synchronizer for the asynchronous serial line plus a
// third flop used to detect a falling edge on the synchronized signal.
// Ports:
//   clk   in  system clock, rising edge
//   rst_n in  synchronous active-low reset (flops reset to the idle-high level)
//   din   in  asynchronous input line
//   dout  out synchronized line (second flop)
//   fall  out high while the synchronized line has just gone 1 -> 0
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic fall
);

  logic rx_s1_q;
  logic rx_s2_q;
  logic rx_s3_q;
  logic rx_s1_d;
  logic rx_s2_d;
  logic rx_s3_d;

  // Next-state of the synchronizer chain.
  always_comb begin
    rx_s1_d = din;
    rx_s2_d = rx_s1_q;
    rx_s3_d = rx_s2_q;
  end

  // Synchronizer flops; reset to 1 so releasing reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_s3_q <= 1'b1;
    end else begin
      rx_s1_q <= rx_s1_d;
      rx_s2_q <= rx_s2_d;
      rx_s3_q <= rx_s3_d;
    end
  end

  assign dout = rx_s2_q;
  assign fall = rx_s3_q & ~rx_s2_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx -- 8N1 UART receiver, LSB first, idle-high line.
// Ports:
//   sclk      in  system clock, rising edge
//   rst_n     in  synchronous active-low reset
//   rx        in  asynchronous serial line
//   po_flag   out one-cycle strobe: po_data holds a newly received byte
//   po_data   out last validly received byte
//   frame_err out one-cycle strobe: stop bit was low, byte discarded
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = CLK_FREQ_DEF,
  parameter int BAUD         = BAUD_DEF,
  parameter int BAUD_CNT_MAX = CLK_FREQ / BAUD
) (
  input  logic       sclk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       po_flag,
  output logic [7:0] po_data,
  output logic       frame_err
);

  localparam int CNT_W = (BAUD_CNT_MAX > 2) ? $clog2(BAUD_CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(BAUD_CNT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(sample_point(BAUD_CNT_MAX));

  logic rx_sync;
  logic rx_fall;

  uart_state_e          state_q;
  uart_state_e          state_d;
  logic [CNT_W-1:0]     baud_cnt_q;
  logic [CNT_W-1:0]     baud_cnt_d;
  logic [2:0]           bit_cnt_q;
  logic [2:0]           bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_d;
  logic [DATA_BITS-1:0] po_data_q;
  logic [DATA_BITS-1:0] po_data_d;
  logic                 po_flag_q;
  logic                 po_flag_d;
  logic                 frame_err_q;
  logic                 frame_err_d;

  logic                 sample_s;
  logic [CNT_W-1:0]     baud_next_s;

  sync_edge u_sync_edge (
    .clk  (sclk),
    .rst_n(rst_n),
    .din  (rx),
    .dout (rx_sync),
    .fall (rx_fall)
  );

  assign sample_s    = (baud_cnt_q == CNT_SAMPLE);
  assign baud_next_s = (baud_cnt_q == CNT_LAST) ? {CNT_W{1'b0}} : (baud_cnt_q + CNT_W'(1));

  // Receive FSM: next state, counters, shift register and output strobes.
  always_comb begin
    state_d     = state_q;
    baud_cnt_d  = baud_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    po_data_d   = po_data_q;
    po_flag_d   = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        baud_cnt_d = {CNT_W{1'b0}};
        bit_cnt_d  = 3'd0;
        if (rx_fall) begin
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        baud_cnt_d = baud_next_s;
        if (sample_s) begin
          // Line back high at mid start bit: a glitch, not a frame.
          if (rx_sync) begin
            state_d    = IDLE;
            baud_cnt_d = {CNT_W{1'b0}};
          end else begin
            state_d   = DATA;
            bit_cnt_d = 3'd0;
          end
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        baud_cnt_d = baud_next_s;
        if (sample_s) begin
          shift_d[bit_cnt_q] = rx_sync;
          if (bit_cnt_q == 3'd7) begin
            state_d   = STOP;
            bit_cnt_d = 3'd0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          state_d = DATA;
        end
      end
      STOP: begin
        baud_cnt_d = baud_next_s;
        if (sample_s) begin
          // Leave mid stop bit so a back-to-back start edge is caught from IDLE.
          state_d    = IDLE;
          baud_cnt_d = {CNT_W{1'b0}};
          if (rx_sync) begin
            po_data_d = shift_q;
            po_flag_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d    = IDLE;
        baud_cnt_d = {CNT_W{1'b0}};
        bit_cnt_d  = 3'd0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      baud_cnt_q  <= {CNT_W{1'b0}};
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      po_data_q   <= 8'h00;
      po_flag_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      po_data_q   <= po_data_d;
      po_flag_q   <= po_flag_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign po_flag   = po_flag_q;
  assign po_data   = po_data_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- self-checking bench for uart_rx at 16 clocks per bit.
// A frame-level model predicts, for every frame sent, which strobe must appear
// and at which cycle; a single compare process checks strobes and po_data on
// every cycle. Directed scenarios add literal expectations.
module tb_uart_rx;

  localparam int BCM = 16;
  localparam int LAT = 8 * BCM + BCM / 2 + BCM + 4;

  logic       sclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       po_flag;
  logic       frame_err;
  logic [7:0] po_data;

  uart_rx #(
    .CLK_FREQ    (50_000_000),
    .BAUD        (9600),
    .BAUD_CNT_MAX(BCM)
  ) dut (
    .sclk     (sclk),
    .rst_n    (rst_n),
    .rx       (rx),
    .po_flag  (po_flag),
    .po_data  (po_data),
    .frame_err(frame_err)
  );

  always #5 sclk = ~sclk;

  int cyc = 0;
  always @(posedge sclk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         due;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] model_data = 8'h00;

  int         obs_flags = 0;
  int         obs_errs = 0;
  int         last_flag_cyc = 0;
  logic [7:0] last_flag_data = 8'h00;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Per-cycle comparison against the frame-level model.
  always @(negedge sclk) begin
    ev_t ev;
    if (rst_n) begin
      chk("strobes_exclusive", {31'd0, po_flag & frame_err}, 32'd0);
      if (po_flag || frame_err) begin
        if (po_flag) begin
          obs_flags++;
          last_flag_cyc  = cyc;
          last_flag_data = po_data;
        end else begin
          obs_errs++;
        end
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", {30'd0, po_flag, frame_err}, 32'd0);
        end else begin
          ev = exp_q.pop_front();
          chk("strobe_kind_err", {31'd0, frame_err}, {31'd0, ev.is_err});
          chk("strobe_latency_ok",
              32'((cyc >= ev.due - 1) && (cyc <= ev.due + 1)), 32'd1);
          if (po_flag) chk("flag_data", {24'd0, po_data}, {24'd0, ev.data});
          if (!ev.is_err) model_data = ev.data;
        end
      end else if (exp_q.size() != 0 && cyc > exp_q[0].due + 1) begin
        ev = exp_q.pop_front();
        chk("missed_strobe", {30'd0, po_flag, frame_err}, ev.is_err ? 32'd1 : 32'd2);
        if (!ev.is_err) model_data = ev.data;
      end
      chk("po_data_hold", {24'd0, po_data}, {24'd0, model_data});
    end
  end

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge sclk);
    #1;
  endtask

  task automatic idle(input int n);
    hold(1'b1, n);
  endtask

  task automatic expect_ev(input bit is_err, input logic [7:0] d);
    ev_t e;
    e.is_err = is_err;
    e.data   = d;
    e.due    = cyc + LAT;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [7:0] b, input logic stop_bit);
    expect_ev(~stop_bit, b);
    hold(1'b0, BCM);
    for (int i = 0; i < 8; i++) hold(b[i], BCM);
    hold(stop_bit, BCM);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    int e0;
    int t0;
    logic [7:0] b;
    logic sb;

    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (4) @(posedge sclk);
    #1;
    chk("rst_po_flag", {31'd0, po_flag}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("rst_po_data", {24'd0, po_data}, 32'h00);
    rst_n = 1'b1;
    idle(20);

    // Single frame 0x55: one flag, about 156 cycles after the start edge.
    f0 = obs_flags; e0 = obs_errs; t0 = cyc;
    send(8'h55, 1'b1);
    idle(40);
    chk("d55_flag_count", 32'(obs_flags - f0), 32'd1);
    chk("d55_data", {24'd0, last_flag_data}, 32'h55);
    chk("d55_latency_ok", 32'((last_flag_cyc - t0 >= 155) && (last_flag_cyc - t0 <= 157)), 32'd1);
    chk("d55_no_err", 32'(obs_errs - e0), 32'd0);

    // Back-to-back frames, no idle gap.
    f0 = obs_flags;
    send(8'hA5, 1'b1);
    send(8'h3C, 1'b1);
    idle(40);
    chk("b2b_flag_count", 32'(obs_flags - f0), 32'd2);
    chk("b2b_last_data", {24'd0, po_data}, 32'h3C);

    // Short low glitch: no strobes at all.
    f0 = obs_flags; e0 = obs_errs;
    hold(1'b0, 5);
    idle(200);
    chk("glitch_no_flag", 32'(obs_flags - f0), 32'd0);
    chk("glitch_no_err", 32'(obs_errs - e0), 32'd0);

    // Bad stop bit: one frame error, data unchanged.
    f0 = obs_flags; e0 = obs_errs;
    send(8'hF0, 1'b0);
    idle(40);
    chk("ferr_count", 32'(obs_errs - e0), 32'd1);
    chk("ferr_no_flag", 32'(obs_flags - f0), 32'd0);
    chk("ferr_data_kept", {24'd0, po_data}, 32'h3C);

    // Reset during data bit 3 of 0x81, then clean 0x7E.
    f0 = obs_flags; e0 = obs_errs;
    hold(1'b0, BCM);
    hold(1'b1, BCM);
    hold(1'b0, BCM);
    hold(1'b0, BCM);
    hold(1'b0, BCM / 2);
    rst_n = 1'b0;
    rx    = 1'b1;
    exp_q.delete();
    model_data = 8'h00;
    repeat (3) @(posedge sclk);
    #1;
    rst_n = 1'b1;
    idle(30);
    chk("abort_no_strobe", 32'(obs_flags - f0 + obs_errs - e0), 32'd0);
    send(8'h7E, 1'b1);
    idle(40);
    chk("after_rst_flag_count", 32'(obs_flags - f0), 32'd1);
    chk("after_rst_data", {24'd0, last_flag_data}, 32'h7E);

    // Break: 40 bit times low gives exactly one frame error, then 0x11.
    f0 = obs_flags; e0 = obs_errs;
    expect_ev(1'b1, 8'h00);
    hold(1'b0, 40 * BCM);
    idle(32);
    chk("break_err_count", 32'(obs_errs - e0), 32'd1);
    chk("break_no_flag", 32'(obs_flags - f0), 32'd0);
    send(8'h11, 1'b1);
    idle(40);
    chk("break_then_11", {24'd0, last_flag_data}, 32'h11);

    // Randomized traffic: frames, bad stop bits, glitches, variable gaps.
    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        hold(1'b0, $urandom_range(1, 6));
        idle(30);
      end else begin
        b  = 8'($urandom);
        sb = ($urandom_range(0, 5) != 0);
        send(b, sb);
        if (sb) idle($urandom_range(0, 20));
        else idle($urandom_range(2, 20));
      end
    end

    idle(200);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
